// File: rtl/writeback_pkg.sv
// Shared writeback definitions: instruction field positions, condition codes,
// special register indices and the {N,Z,C,V} flag bit order.
package writeback_pkg;

  localparam int IMB_BIT  = 31;
  localparam int RA_LSB   = 27;
  localparam int RB_LSB   = 23;
  localparam int RC_LSB   = 4;
  localparam int COND_LSB = 1;
  localparam int CMP_BIT  = 0;

  localparam int         NUM_GPR = 14;
  localparam logic [3:0] REG_PC  = 4'hE;
  localparam logic [3:0] REG_OVF = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_MI = 3'd3,
    COND_PL = 3'd4,
    COND_CS = 3'd5,
    COND_CC = 3'd6,
    COND_VS = 3'd7
  } cond_e;

  function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] flags);
    logic pass;
    pass = 1'b1;
    case (cond_e'(cond))
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLAG_Z];
      COND_NE: pass = !flags[FLAG_Z];
      COND_MI: pass = flags[FLAG_N];
      COND_PL: pass = !flags[FLAG_N];
      COND_CS: pass = flags[FLAG_C];
      COND_CC: pass = !flags[FLAG_C];
      COND_VS: pass = flags[FLAG_V];
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding-write counters (2-bit, saturating) for r0..r13 and overflow, plus decode hazard.
// WRITEBACK_FORWARD_EN lets a register whose last pending write commits this cycle stop hazarding.
module wb_scoreboard
  import writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_stall,
  input  logic       i_issue_vld,
  input  logic       i_dec_imb,
  input  logic [3:0] i_dec_ra,
  input  logic [3:0] i_dec_rb,
  input  logic [3:0] i_dec_rc,
  input  logic       i_dec_cmp,
  input  logic       i_wb_vld,
  input  logic [3:0] i_wb_rc,
  input  logic       i_wb_cmp,
  input  logic       i_wb_commit,
  output logic       o_hazard
);

  localparam logic [1:0] CNT_MAX = 2'd3;

  logic [1:0]  r_cnt [16];
  logic [15:0] w_busy;
  logic [15:0] w_up;
  logic [15:0] w_dn;
  logic        w_sat;
  logic        w_inc;
  logic        w_dec;

  // A full counter blocks a further write issue to the same register.
  assign w_sat    = !i_dec_cmp && (i_dec_rc != REG_PC) && (r_cnt[i_dec_rc] == CNT_MAX);
  assign o_hazard = ((i_dec_ra != REG_PC) && w_busy[i_dec_ra])
                 || (!i_dec_imb && (i_dec_rb < REG_PC) && w_busy[i_dec_rb])
                 || w_sat;
  assign w_inc    = i_issue_vld && !o_hazard && !i_dec_cmp && (i_dec_rc != REG_PC);
  assign w_dec    = i_wb_vld && !i_wb_cmp && (i_wb_rc != REG_PC);

  always_comb begin
    w_busy = '0;
    w_up   = '0;
    w_dn   = '0;
    for (int i = 0; i < 16; i++) begin
      w_busy[i] = (r_cnt[i] != 2'd0);
`ifdef WRITEBACK_FORWARD_EN
      if ((r_cnt[i] == 2'd1) && i_wb_commit && !i_wb_cmp && (i_wb_rc == 4'(i)))
        w_busy[i] = 1'b0;
`endif
      w_up[i] = w_inc && (i_dec_rc == 4'(i));
      w_dn[i] = w_dec && (i_wb_rc == 4'(i));
    end
  end

`ifndef WRITEBACK_FORWARD_EN
  logic w_unused_commit;
  assign w_unused_commit = i_wb_commit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_cnt[i] <= 2'd0;
    end else if (!i_stall) begin
      for (int i = 0; i < 16; i++) begin
        if (w_up[i] && !w_dn[i] && (r_cnt[i] != CNT_MAX))
          r_cnt[i] <= r_cnt[i] + 2'd1;
        else if (w_dn[i] && !w_up[i] && (r_cnt[i] != 2'd0))
          r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: conditional commit to r0..r13 / PC redirect / overflow, post-redirect squash, issue scoreboard.
// Optional macro WRITEBACK_FORWARD_EN: combinational r/overflow outputs and same-cycle hazard release.
module writeback
  import writeback_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] instructionWriteback,
  input  logic [31:0] result,
  input  logic        resultValid,
  input  logic [3:0]  flagsIn,
  input  logic [31:0] overflowIn,
  input  logic        overflowWe,
  input  logic [31:0] decodeInstruction,
  input  logic        issueValid,
  output logic [31:0] r [NUM_GPR],
  output logic [31:0] overflow,
  output logic        pcWe,
  output logic [31:0] pcNew,
  output logic        flush,
  output logic        hazard
);

  localparam int SQ_W = $clog2(FLUSH_DEPTH + 2);

  logic [31:0]     r_regs [NUM_GPR];
  logic [31:0]     r_ovf;
  logic [3:0]      r_flags;
  logic [SQ_W-1:0] r_squash;
  logic            r_pc_we;
  logic            r_flush;
  logic [31:0]     r_pc_new;

  logic [3:0] w_wb_rc;
  logic [2:0] w_wb_cond;
  logic       w_wb_cmp;
  logic       w_commit;
  logic       w_wr_gpr;
  logic       w_wr_pc;
  logic       w_wr_ovf;
  logic       w_unused;

  assign w_wb_rc   = instructionWriteback[RC_LSB +: 4];
  assign w_wb_cond = instructionWriteback[COND_LSB +: 3];
  assign w_wb_cmp  = instructionWriteback[CMP_BIT];

  assign w_commit = resultValid && cond_pass(w_wb_cond, r_flags) && (r_squash == '0) && !stall;
  assign w_wr_gpr = w_commit && !w_wb_cmp && (w_wb_rc < REG_PC);
  assign w_wr_pc  = w_commit && !w_wb_cmp && (w_wb_rc == REG_PC);
  assign w_wr_ovf = w_commit && !w_wb_cmp && (w_wb_rc == REG_OVF);

  assign w_unused = ^{instructionWriteback[31:8], decodeInstruction[22:8],
                      decodeInstruction[COND_LSB +: 3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) r_regs[i] <= '0;
      r_ovf    <= '0;
      r_flags  <= '0;
      r_squash <= '0;
      r_pc_we  <= 1'b0;
      r_flush  <= 1'b0;
      r_pc_new <= '0;
    end else if (!stall) begin
      if (w_commit && w_wb_cmp) r_flags <= flagsIn;
      for (int i = 0; i < NUM_GPR; i++)
        if (w_wr_gpr && (w_wb_rc == 4'(i))) r_regs[i] <= result;
      // An architectural overflow write outranks the execute-side side channel.
      if (w_wr_ovf)        r_ovf <= result;
      else if (overflowWe) r_ovf <= overflowIn;
      r_pc_we <= w_wr_pc;
      r_flush <= w_wr_pc;
      if (w_wr_pc) r_pc_new <= result;
      if (w_wr_pc)
        r_squash <= SQ_W'(FLUSH_DEPTH);
      else if (resultValid && (r_squash != '0))
        r_squash <= r_squash - 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) r[i] = r_regs[i];
    overflow = r_ovf;
`ifdef WRITEBACK_FORWARD_EN
    for (int i = 0; i < NUM_GPR; i++)
      if (w_wr_gpr && (w_wb_rc == 4'(i))) r[i] = result;
    if (w_wr_ovf) overflow = result;
`endif
  end

  assign pcWe  = r_pc_we;
  assign flush = r_flush;
  assign pcNew = r_pc_new;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (stall),
    .i_issue_vld (issueValid),
    .i_dec_imb   (decodeInstruction[IMB_BIT]),
    .i_dec_ra    (decodeInstruction[RA_LSB +: 4]),
    .i_dec_rb    (decodeInstruction[RB_LSB +: 4]),
    .i_dec_rc    (decodeInstruction[RC_LSB +: 4]),
    .i_dec_cmp   (decodeInstruction[CMP_BIT]),
    .i_wb_vld    (resultValid),
    .i_wb_rc     (w_wb_rc),
    .i_wb_cmp    (w_wb_cmp),
    .i_wb_commit (w_commit),
    .o_hazard    (hazard)
  );

endmodule

// File: tb/tb_writeback.sv
// Directed and random bench for writeback; the model keeps in-flight instructions in a queue
// and derives pending-write counts, squash and commit effects from that queue.
module tb_writeback;

  localparam int FD = 2;
  localparam logic [3:0] E = 4'hE;

  logic        clk = 1'b0;
  logic        rst, stall, resultValid, overflowWe, issueValid;
  logic [31:0] instructionWriteback, result, overflowIn, decodeInstruction;
  logic [3:0]  flagsIn;
  logic [31:0] r_o [14];
  logic [31:0] overflow_o, pcNew_o;
  logic        pcWe_o, flush_o, hazard_o;

  writeback #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .instructionWriteback(instructionWriteback), .result(result), .resultValid(resultValid),
    .flagsIn(flagsIn), .overflowIn(overflowIn), .overflowWe(overflowWe),
    .decodeInstruction(decodeInstruction), .issueValid(issueValid),
    .r(r_o), .overflow(overflow_o), .pcWe(pcWe_o), .pcNew(pcNew_o), .flush(flush_o),
    .hazard(hazard_o)
  );

  always #5 clk = ~clk;

  logic [31:0] m_r [14];
  logic [31:0] m_ovf, m_pcnew;
  logic        m_pcwe;
  logic [3:0]  m_flags;
  int          m_sq;
  logic [31:0] q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] mk(input bit imb, input bit [3:0] ra, input bit [3:0] rb,
                                     input bit [3:0] rc, input bit [2:0] cond, input bit cmp);
    logic [31:0] v;
    v = '0;
    v[31] = imb; v[30:27] = ra; v[26:23] = rb; v[7:4] = rc; v[3:1] = cond; v[0] = cmp;
    return v;
  endfunction

  // Number of queued (issued, not yet arrived) instructions that write register idx.
  function automatic int pend(input logic [3:0] idx);
    int c = 0;
    foreach (q[k]) if (!q[k][0] && q[k][7:4] == idx) c++;
    return c;
  endfunction

  function automatic bit [3:0] pick();
    case ($urandom % 6)
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd3;
      4: return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 14; i++) chk($sformatf("r%0d", i), r_o[i], m_r[i]);
    chk("overflow", overflow_o, m_ovf);
    chk("pcWe", {31'b0, pcWe_o}, {31'b0, m_pcwe});
    chk("flush", {31'b0, flush_o}, {31'b0, m_pcwe});
    chk("pcNew", pcNew_o, m_pcnew);
  endtask

  task automatic cycle(input logic [31:0] dec, input bit iv, input bit dowb, input logic [31:0] res,
                       input logic [3:0] fl, input bit ow, input logic [31:0] oin, input bit st);
    logic [31:0] wbi;
    logic [3:0]  ra, rb, drc, rc;
    bit          cp, cm, eh;
    int          cra, crb;
    if (q.size() == 0) dowb = 0;
    wbi = dowb ? q[0] : 32'h0;
    decodeInstruction = dec; issueValid = iv; instructionWriteback = wbi; resultValid = dowb;
    result = res; flagsIn = fl; overflowWe = ow; overflowIn = oin; stall = st;
    case (wbi[3:1])
      3'd0: cp = 1;
      3'd1: cp = m_flags[2];
      3'd2: cp = !m_flags[2];
      3'd3: cp = m_flags[3];
      3'd4: cp = !m_flags[3];
      3'd5: cp = m_flags[1];
      3'd6: cp = !m_flags[1];
      default: cp = m_flags[0];
    endcase
    cm  = dowb && cp && (m_sq == 0) && !st;
    rc  = wbi[7:4];
    ra  = dec[30:27]; rb = dec[26:23]; drc = dec[7:4];
    cra = pend(ra); crb = pend(rb);
`ifdef WRITEBACK_FORWARD_EN
    if (cm && !wbi[0] && rc == ra && cra == 1) cra = 0;
    if (cm && !wbi[0] && rc == rb && crb == 1) crb = 0;
`endif
    eh = (ra != E && cra > 0) || (!dec[31] && rb < E && crb > 0)
      || (!dec[0] && drc != E && pend(drc) >= 3);
    #2;
    chk("hazard", {31'b0, hazard_o}, {31'b0, eh});
    if (!st) begin
      if (dowb) void'(q.pop_front());
      if (iv && !eh) q.push_back(dec);
      m_pcwe = cm && !wbi[0] && rc == E;
      if (cm && wbi[0]) m_flags = fl;
      if (cm && !wbi[0] && rc < E) m_r[rc] = res;
      if (cm && !wbi[0] && rc == 4'hF) m_ovf = res;
      else if (ow) m_ovf = oin;
      if (m_pcwe) begin m_pcnew = res; m_sq = FD; end
      else if (dowb && m_sq > 0) m_sq--;
    end
    @(posedge clk); #1;
    resultValid = 0; issueValid = 0; overflowWe = 0; stall = 0;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; stall = 1; resultValid = 1; issueValid = 1; overflowWe = 1;
    instructionWriteback = mk(1, 0, 0, 4'd3, 0, 0); result = 32'hBAD0BAD0;
    overflowIn = 32'h0BAD; flagsIn = 4'hF; decodeInstruction = mk(1, 4'd3, 0, E, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 0; stall = 0; resultValid = 0; issueValid = 0; overflowWe = 0;
    q.delete();
    for (int i = 0; i < 14; i++) m_r[i] = '0;
    m_ovf = '0; m_pcnew = '0; m_pcwe = 0; m_flags = '0; m_sq = 0;
    #1;
    check_all();
    chk("rst_hazard", {31'b0, hazard_o}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] x);
    cycle(x, 1, 0, 32'h0, 4'h0, 0, 32'h0, 0);
  endtask

  task automatic wb(input logic [31:0] res, input logic [3:0] fl);
    cycle(mk(1, E, 0, E, 0, 1), 0, 1, res, fl, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1; stall = 0; resultValid = 0; overflowWe = 0; issueValid = 0;
    instructionWriteback = '0; result = '0; overflowIn = '0; decodeInstruction = '0; flagsIn = '0;
    do_reset();

    // Unconditional write to r3
    issue(mk(1, E, 0, 4'd3, 0, 0));
    wb(32'hDEADBEEF, 0);
    chk("r3_write", r_o[3], 32'hDEADBEEF);
    chk("r2_untouched", r_o[2], 32'h0);

    // Compare loads Z; EQ write lands, NE write is dropped but still retires its count
    issue(mk(1, E, 0, 0, 0, 1));
    issue(mk(1, E, 0, 4'd5, 3'd1, 0));
    issue(mk(1, E, 0, 4'd6, 3'd2, 0));
    wb(32'h0, 4'b0100);
    wb(32'h55, 4'h0);
    wb(32'h66, 4'h0);
    chk("r5_eq_pass", r_o[5], 32'h55);
    chk("r6_ne_fail", r_o[6], 32'h0);
    cycle(mk(1, 4'd6, 0, E, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    chk("cnt6_released", {31'b0, hazard_o}, 32'd0);

    // PC redirect squashes the next two arrivals
    issue(mk(1, E, 0, E, 0, 0));
    issue(mk(1, E, 0, 4'd7, 0, 0));
    issue(mk(1, E, 0, 4'd8, 0, 0));
    issue(mk(1, E, 0, 4'd9, 0, 0));
    wb(32'h100, 0);
    chk("pc_we", {31'b0, pcWe_o}, 32'd1);
    chk("pc_flush", {31'b0, flush_o}, 32'd1);
    chk("pc_new", pcNew_o, 32'h100);
    wb(32'h77, 0);
    chk("pc_we_pulse", {31'b0, pcWe_o}, 32'd0);
    chk("r7_squashed", r_o[7], 32'h0);
    wb(32'h88, 0);
    chk("r8_squashed", r_o[8], 32'h0);
    wb(32'h99, 0);
    chk("r9_after_squash", r_o[9], 32'h99);

    // Ra and Rb read-after-write hazards
    issue(mk(1, E, 0, 4'd2, 0, 0));
    cycle(mk(1, 4'd2, 0, E, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    chk("haz_ra_pending", {31'b0, hazard_o}, 32'd1);
    cycle(mk(1, 4'd2, 0, E, 0, 1), 0, 1, 32'h222, 0, 0, 0, 0);
    chk("haz_ra_released", {31'b0, hazard_o}, 32'd0);
    issue(mk(1, E, 0, 4'd2, 0, 0));
    cycle(mk(0, E, 4'd2, E, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    chk("haz_rb_pending", {31'b0, hazard_o}, 32'd1);
    wb(32'h333, 0);
    chk("haz_rb_released", {31'b0, hazard_o}, 32'd0);

    // Overflow priority and overflowWe alone
    issue(mk(1, E, 0, 4'hF, 0, 0));
    cycle(mk(1, E, 0, E, 0, 1), 0, 1, 32'h22, 0, 1, 32'h11, 0);
    chk("ovf_commit_wins", overflow_o, 32'h22);
    cycle(mk(1, E, 0, E, 0, 1), 0, 0, 0, 0, 1, 32'h33, 0);
    chk("ovf_we", overflow_o, 32'h33);

    // Reset in the middle of a squash
    issue(mk(1, E, 0, E, 0, 0));
    issue(mk(1, E, 0, 4'd4, 0, 0));
    issue(mk(1, E, 0, 4'd4, 0, 0));
    wb(32'h200, 0);
    do_reset();
    cycle(mk(1, 4'd4, 0, E, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt4_clear", {31'b0, hazard_o}, 32'd0);
    issue(mk(1, E, 0, 4'd4, 0, 0));
    wb(32'h44, 0);
    chk("rst_squash_clear", r_o[4], 32'h44);

    // Counter saturation blocks a fourth write issue
    repeat (3) issue(mk(1, E, 0, 4'd10, 0, 0));
    cycle(mk(1, E, 0, 4'd10, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    chk("sat_hazard", {31'b0, hazard_o}, 32'd1);
    repeat (3) wb(32'hA0A0, 0);

    // Stall freezes commit and overflowWe
    issue(mk(1, E, 0, 4'd11, 0, 0));
    cycle(mk(1, E, 0, E, 0, 1), 0, 1, 32'hABC, 0, 1, 32'h5, 1);
    chk("stall_r11", r_o[11], 32'h0);
    chk("stall_ovf", overflow_o, 32'h0);
    wb(32'hABC, 0);
    chk("unstall_r11", r_o[11], 32'hABC);

    for (int k = 0; k < 3000; k++) begin
      cycle(mk(($urandom % 2) == 1, pick(), pick(), pick(), 3'($urandom), ($urandom % 4) == 0),
            ($urandom % 2) == 1, ($urandom % 4) != 0, $urandom, 4'($urandom),
            ($urandom % 4) == 0, $urandom, ($urandom % 8) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
